// File: rtl/vector_mem_unit.sv
// Vector memory unit: sequences 16-element vector loads/stores
// and single-element stores over a 16-bit word memory port.
module vector_mem_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   opcode,
  input  logic [15:0]  addr,
  input  logic [255:0] st_data,
  output logic         busy,
  output logic         done,
  output logic [255:0] ld_data,
  output logic [15:0]  mem_addr,
  output logic [15:0]  mem_wdata,
  output logic         mem_re,
  output logic         mem_we,
  input  logic [15:0]  mem_rdata
);

  localparam logic [3:0] OP_VLD = 4'b0100;
  localparam logic [3:0] OP_VST = 4'b0101;
  localparam logic [3:0] OP_SST = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_TAIL,
    STORE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic         is_mem;
  logic         accept;
  logic         sst_q;
  logic [15:0]  base_q;
  logic [239:0] sd_q;
  logic [4:0]   cnt;
  logic [4:0]   cnt_n;
  logic [3:0]   sel;
  logic         rd_pend;
  logic [3:0]   cap_idx;
  logic         re_n;
  logic         we_n;
  logic [15:0]  addr_n;
  logic [15:0]  wd_n;

  assign is_mem = (opcode == OP_VLD) ||
                  (opcode == OP_VST) ||
                  (opcode == OP_SST);

  // The first element lives in st_data; sd_q keeps elements 1..15.
  assign sel = cnt[3:0] - 4'd1;

  // New requests are taken only when idle or in the done cycle.
  always_comb begin
    accept = start && is_mem &&
             ((state == IDLE) || (state == DONE));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and next registered-output values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    re_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = 16'h0000;
    wd_n    = 16'h0000;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          cnt_n  = 5'd1;
          addr_n = addr;
          if (opcode == OP_VLD) begin
            state_n = LOAD;
            re_n    = 1'b1;
          end else begin
            state_n = STORE;
            we_n    = 1'b1;
            wd_n    = st_data[15:0];
          end
        end
      end
      LOAD: begin
        if (cnt[4]) begin
          state_n = LOAD_TAIL;
        end else begin
          re_n   = 1'b1;
          addr_n = base_q + {11'b0, cnt};
          cnt_n  = cnt + 5'd1;
        end
      end
      LOAD_TAIL: state_n = DONE;
      STORE: begin
        if (cnt[4] || sst_q) begin
          state_n = DONE;
        end else begin
          we_n   = 1'b1;
          addr_n = base_q + {11'b0, cnt};
          wd_n   = sd_q[{sel, 4'b0000} +: 16];
          cnt_n  = cnt + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs, operand latches and load capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      ld_data   <= '0;
      cnt       <= 5'd0;
      sst_q     <= 1'b0;
      base_q    <= 16'h0000;
      sd_q      <= '0;
      rd_pend   <= 1'b0;
      cap_idx   <= 4'd0;
    end else begin
      busy      <= (state_n == LOAD) ||
                   (state_n == LOAD_TAIL) ||
                   (state_n == STORE);
      done      <= (state_n == DONE);
      mem_re    <= re_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wd_n;
      cnt       <= cnt_n;
      rd_pend   <= mem_re;
      if (rd_pend) begin
        ld_data[{cap_idx, 4'b0000} +: 16] <= mem_rdata;
        cap_idx <= cap_idx + 4'd1;
      end
      if (accept) begin
        sst_q  <= (opcode == OP_SST);
        base_q <= addr;
        sd_q   <= st_data[255:16];
        if (opcode == OP_VLD) cap_idx <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit with a
// behavioural memory and a per-operation access model.
module tb_vector_mem_unit;

  localparam logic [3:0] VLD = 4'b0100;
  localparam logic [3:0] VST = 4'b0101;
  localparam logic [3:0] SST = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [15:0]  addr;
  logic [255:0] st_data;
  logic         busy;
  logic         done;
  logic [255:0] ld_data;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic         mem_re;
  logic         mem_we;
  logic [15:0]  mem_rdata;

  always #5 clk = ~clk;

  vector_mem_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .st_data   (st_data),
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  int checks = 0;
  int fails  = 0;

  logic [15:0]  mem     [0:65535];
  logic [15:0]  ref_mem [0:65535];
  logic [255:0] ref_ld;

  // Memory: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr] : 16'($urandom);
  end

  typedef struct {
    logic [3:0]   op;
    logic [15:0]  a;
    logic [255:0] sd;
    int           poke;
    int           lat;
  } vec_t;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and test the
  // always-true port invariants.
  task automatic tick;
    logic bad;
    @(negedge clk);
    bad = (mem_re && mem_we) ||
          (!mem_re && !mem_we &&
           (mem_addr != 16'h0 || mem_wdata != 16'h0)) ||
          (done && busy);
    chk("invariant", {255'b0, bad}, 256'b0);
  endtask

  function automatic int lat_of(input logic [3:0] op);
    if (op == VLD) return 17;
    if (op == VST) return 16;
    if (op == SST) return 1;
    return -1;
  endfunction

  function automatic logic [255:0] elems(input logic [15:0] a);
    logic [255:0] v;
    for (int k = 0; k < 16; k++)
      v[k*16 +: 16] = ref_mem[16'(a + 16'(k))];
    return v;
  endfunction

  // Run one request; sample j is the cycle after edge Ej.
  task automatic do_op(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [255:0] sd,
                       input int poke,
                       input int lat);
    logic         re_e, we_e, dn_e, bz_e;
    logic [15:0]  ad_e, wd_e;
    logic [255:0] act, exp, got;
    int n;
    n = (op == VLD || op == VST) ? 16 : (op == SST ? 1 : 0);
    if (op == VLD) ref_ld = elems(a);
    opcode  = op;
    addr    = a;
    st_data = sd;
    start   = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      start   = 1'b0;
      opcode  = 4'($urandom);
      addr    = 16'($urandom);
      st_data = {8{$urandom}};
      re_e = (op == VLD) && (j < n);
      we_e = (op != VLD) && (j < n);
      ad_e = (re_e || we_e) ? 16'(a + 16'(j)) : 16'h0;
      wd_e = we_e ? sd[j*16 +: 16] : 16'h0;
      dn_e = (j == lat);
      bz_e = (j < lat);
      act = {218'b0, busy, done, mem_re, mem_we,
             mem_addr, mem_wdata};
      exp = {218'b0, bz_e, dn_e, re_e, we_e, ad_e, wd_e};
      chk($sformatf("trace op%0h j%0d", op, j), act, exp);
      if (j == poke) begin
        start  = 1'b1;
        opcode = VLD;
        addr   = 16'(a + 16'h1234);
      end
    end
    chk("ld_data", ld_data, ref_ld);
    if (n > 0 && op != VLD) begin
      exp = '0;
      got = '0;
      for (int k = 0; k < n; k++) begin
        ref_mem[16'(a + 16'(k))] = sd[k*16 +: 16];
        exp[k*16 +: 16] = sd[k*16 +: 16];
        got[k*16 +: 16] = mem[16'(a + 16'(k))];
      end
      chk("memory after store", got, exp);
    end
  endtask

  vec_t vt [$];
  logic [255:0] ramp;
  logic [255:0] rsd;
  int           cyc;
  logic [3:0]   rop;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    opcode  = 4'h0;
    addr    = 16'h0;
    st_data = '0;
    ref_ld  = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end
    for (int i = 0; i < 16; i++) begin
      mem[16'h0100 + i]     = 16'h3C00 + 16'(i);
      ref_mem[16'h0100 + i] = 16'h3C00 + 16'(i);
      ramp[i*16 +: 16]      = 16'(i);
    end

    tick();
    tick();
    chk("reset outputs",
        {busy, done, mem_re, mem_we, mem_addr, mem_wdata, ld_data},
        '0);
    rst_n = 1'b1;
    tick();

    vt.push_back('{VLD, 16'h0100, '0, -1, 17});
    vt.push_back('{VST, 16'hFFF8, ramp, -1, 16});
    vt.push_back('{SST, 16'h0042, {240'h0, 16'hBEEF}, -1, 1});
    vt.push_back('{4'b0000, 16'h0077, ramp, -1, -1});
    vt.push_back('{VST, 16'h0500, ~ramp, 4, 16});
    vt.push_back('{VLD, 16'hFFF8, '0, -1, 17});
    foreach (vt[i])
      do_op(vt[i].op, vt[i].a, vt[i].sd, vt[i].poke, vt[i].lat);
    chk("vld 0x100 elem 5", {240'b0, 16'h3C05},
        {240'b0, ref_mem[16'h0105]});

    // Reset in the middle of a load.
    opcode = VLD;
    addr   = 16'h0200;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j < 8; j++) tick();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset", {busy, done, mem_re, ld_data}, '0);
    ref_ld = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("quiet after reset", {253'b0, done, busy, mem_re}, '0);
    end
    do_op(VLD, 16'h0200, '0, -1, 17);

    // Store, then load accepted in the done cycle.
    rsd = {8{$urandom}};
    opcode  = VST;
    addr    = 16'h0300;
    st_data = rsd;
    start   = 1'b1;
    cyc = 0;
    do begin
      tick();
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 40);
    chk("chain vst done cycle", 256'(cyc - 1), 256'd16);
    for (int k = 0; k < 16; k++)
      ref_mem[16'h0300 + k] = rsd[k*16 +: 16];
    opcode = VLD;
    addr   = 16'h0300;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("chain first read",
        {222'b0, mem_re, mem_we, mem_addr, done, busy},
        {222'b0, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b1});
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("chain vld done cycle", 256'(cyc), 256'd17);
    ref_ld = rsd;
    chk("chain ld_data", ld_data, ref_ld);
    tick();

    // Random requests.
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: rop = VLD;
        1: rop = VST;
        2: rop = SST;
        default: begin
          do rop = 4'($urandom);
          while (rop == VLD || rop == VST || rop == SST);
        end
      endcase
      do_op(rop, 16'($urandom), {8{$urandom}}, -1, lat_of(rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
